// File: rtl/flash_update_pkg.sv
// flash_update_pkg
// Shared definitions for the flash update engine: FSM state encoding,
// default CSR word addresses of the ASMI flash controller and the
// position of the write-in-progress flag in the status register.
package flash_update_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHK,
        SET_OFS,
        ERASE,
        POLL_RD,
        POLL_WAIT,
        FILL,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] CSR_OFFSET_ADDR = 16'h0064;
    localparam logic [15:0] CSR_ERASE_ADDR  = 16'h0007;
    localparam logic [15:0] CSR_STATUS_ADDR = 16'h0002;

    localparam int WIP_BIT = 0;

endpackage

// File: rtl/flash_update_fifo.sv
// flash_update_fifo
// Synchronous first-word-fall-through FIFO that stages incoming data words
// until a full flash page burst is available.
// Ports:
//   clock, reset_n  : clock, async active-low reset
//   flush           : synchronous clear of all contents
//   push, push_data : write side (ignored while full)
//   pop, pop_data   : read side; pop_data always shows the oldest word
//   full, empty     : occupancy flags
//   count           : number of stored words (0..DEPTH)
module flash_update_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only words below count are ever read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flash_update_engine.sv
// flash_update_engine
// Avalon-MM master that turns a (flash byte address, word count, erase)
// command plus a stream of 32-bit data words into ASMI flash controller
// traffic: page-offset CSR writes, optional sector erase with WIP polling,
// and page-aligned write bursts.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   cmd_*                   : command handshake (accepted only while idle)
//   din_*                   : data word stream
//   busy, done, error       : status; done pulses once per command,
//                             error (erase timeout) is sticky until next accept
//   ams_mem_*               : Avalon-MM master towards the flash controller;
//                             address bit16 selects the CSR space
module flash_update_engine
    import flash_update_pkg::*;
#(
    parameter int          BURST_MAX      = 64,
    parameter int          SECTOR_WORDS   = 16384,
    parameter logic [15:0] CSR_OFFSET_REG = CSR_OFFSET_ADDR,
    parameter logic [15:0] CSR_ERASE_REG  = CSR_ERASE_ADDR,
    parameter logic [15:0] CSR_STATUS_REG = CSR_STATUS_ADDR,
    parameter logic [23:0] POLL_TIMEOUT   = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [23:0] cmd_words,
    input  logic        cmd_erase,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ams_mem_read,
    output logic        ams_mem_write,
    output logic [16:0] ams_mem_address,
    output logic [6:0]  ams_mem_burstcount,
    output logic [31:0] ams_mem_writedata,
    input  logic        ams_mem_waitrequest,
    input  logic [31:0] ams_mem_readdata,
    input  logic        ams_mem_readdatavalid
);

    localparam logic [29:0] PAGE_MASK   = 30'(BURST_MAX - 1);
    localparam logic [29:0] SECTOR_MASK = 30'(SECTOR_WORDS - 1);

    state_t                    state;
    state_t                    next_state;
    logic [29:0]               waddr;
    logic [23:0]               rem;
    logic                      erase_flag;
    logic                      first_flag;
    logic [15:0]               cur_ofs;
    logic [23:0]               poll_cnt;
    logic [6:0]                beat_cnt;
    logic                      error_q;

    logic                      cmd_accept;
    logic [15:0]               new_ofs;
    logic [6:0]                page_room;
    logic [6:0]                blen;
    logic                      last_beat;
    logic                      fill_ready;
    logic                      wip;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [31:0]               fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(BURST_MAX):0] fifo_count;
    logic                      unused_bits;

    assign cmd_accept  = cmd_valid && cmd_ready;
    assign new_ofs     = {2'b00, waddr[29:16]};
    // Bursts stop at the page end, so they can never cross a 64K-word
    // offset window or an erase sector either.
    assign page_room   = 7'(BURST_MAX) - 7'(waddr & PAGE_MASK);
    assign blen        = (rem < 24'(page_room)) ? 7'(rem) : page_room;
    assign last_beat   = (beat_cnt == blen - 7'd1);
    assign fill_ready  = (32'(fifo_count) >= 32'(blen));
    assign wip         = ams_mem_readdata[WIP_BIT];
    assign fifo_push   = din_valid && din_ready;
    assign fifo_pop    = (state == WRITE) && !ams_mem_waitrequest;
    assign error       = error_q;
    assign unused_bits = ^{ams_mem_readdata, cmd_addr[1:0], fifo_empty};

    // The FIFO is cleared on every command accept so words left over from an
    // aborted command can never leak into the next one.
    flash_update_fifo #(
        .DEPTH (BURST_MAX),
        .WIDTH (32)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (cmd_accept),
        .push      (fifo_push),
        .push_data (din_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero-word command skips CHK so done follows the accept immediately.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    next_state = (cmd_words == 24'd0) ? DONE : CHK;
                end
            end
            CHK: begin
                if (rem == 24'd0) begin
                    next_state = DONE;
                end else if (new_ofs != cur_ofs) begin
                    next_state = SET_OFS;
                end else if (erase_flag && (((waddr & SECTOR_MASK) == 30'd0) || first_flag)) begin
                    next_state = ERASE;
                end else begin
                    next_state = FILL;
                end
            end
            SET_OFS: if (!ams_mem_waitrequest) next_state = CHK;
            ERASE:   if (!ams_mem_waitrequest) next_state = POLL_RD;
            POLL_RD: if (!ams_mem_waitrequest) next_state = POLL_WAIT;
            POLL_WAIT: begin
                if (ams_mem_readdatavalid) begin
                    if (!wip) begin
                        next_state = FILL;
                    end else if (poll_cnt == POLL_TIMEOUT - 24'd1) begin
                        next_state = ERR;
                    end else begin
                        next_state = POLL_RD;
                    end
                end
            end
            FILL:    if (fill_ready) next_state = WRITE;
            WRITE:   if (!ams_mem_waitrequest && last_beat) next_state = CHK;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command datapath. cur_ofs starts invalid so the first command after
    // reset always programs the offset register. first_flag forces an erase
    // of the sector holding the first word even when it is not sector-aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waddr      <= '0;
            rem        <= '0;
            erase_flag <= 1'b0;
            first_flag <= 1'b0;
            cur_ofs    <= 16'hFFFF;
            poll_cnt   <= '0;
            beat_cnt   <= '0;
            error_q    <= 1'b0;
        end else begin
            if (cmd_accept) begin
                waddr      <= cmd_addr[31:2];
                rem        <= cmd_words;
                erase_flag <= cmd_erase;
                first_flag <= 1'b1;
                error_q    <= 1'b0;
            end
            case (state)
                SET_OFS: begin
                    if (!ams_mem_waitrequest) cur_ofs <= new_ofs;
                end
                ERASE: begin
                    if (!ams_mem_waitrequest) poll_cnt <= '0;
                end
                POLL_WAIT: begin
                    if (ams_mem_readdatavalid && wip) begin
                        if (poll_cnt == POLL_TIMEOUT - 24'd1) begin
                            error_q <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 24'd1;
                        end
                    end
                end
                WRITE: begin
                    if (!ams_mem_waitrequest) begin
                        if (last_beat) begin
                            beat_cnt   <= '0;
                            waddr      <= waddr + 30'(blen);
                            rem        <= rem - 24'(blen);
                            first_flag <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; everything is a function of state and held registers,
    // so bus signals stay stable for as long as waitrequest is high.
    always_comb begin
        cmd_ready          = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        din_ready          = 1'b0;
        ams_mem_read       = 1'b0;
        ams_mem_write      = 1'b0;
        ams_mem_address    = '0;
        ams_mem_burstcount = '0;
        ams_mem_writedata  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            SET_OFS: begin
                ams_mem_write      = 1'b1;
                ams_mem_address    = {1'b1, CSR_OFFSET_REG};
                ams_mem_burstcount = 7'd1;
                ams_mem_writedata  = {16'h0000, new_ofs};
            end
            ERASE: begin
                ams_mem_write      = 1'b1;
                ams_mem_address    = {1'b1, CSR_ERASE_REG};
                ams_mem_burstcount = 7'd1;
                ams_mem_writedata  = {waddr & ~SECTOR_MASK, 2'b00};
            end
            POLL_RD: begin
                ams_mem_read       = 1'b1;
                ams_mem_address    = {1'b1, CSR_STATUS_REG};
                ams_mem_burstcount = 7'd1;
            end
            FILL: begin
                din_ready = !fifo_full;
            end
            WRITE: begin
                din_ready          = !fifo_full;
                ams_mem_write      = 1'b1;
                ams_mem_address    = {1'b0, waddr[15:0]};
                ams_mem_burstcount = blen;
                ams_mem_writedata  = fifo_data;
            end
            DONE: done = 1'b1;
            ERR:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_update_engine.sv
// tb_flash_update_engine
// Directed bench for flash_update_engine. A small Avalon slave answers the
// engine (configurable waitrequest stalls, scripted status reads) and logs
// every accepted transfer; each command's log is compared against a
// hand-written list of expected transfers.
module tb_flash_update_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [23:0] cmd_words;
    logic        cmd_erase;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        ams_mem_read;
    logic        ams_mem_write;
    logic [16:0] ams_mem_address;
    logic [6:0]  ams_mem_burstcount;
    logic [31:0] ams_mem_writedata;
    logic        ams_mem_waitrequest;
    logic [31:0] ams_mem_readdata;
    logic        ams_mem_readdatavalid;

    typedef struct {
        bit          is_read;
        logic [16:0] addr;
        logic [6:0]  bc;
        logic [31:0] data;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] status_q[$];
    logic [31:0] status_default = 32'h0;
    int          stall_cycles = 0;
    bit          cmd_finished;
    int          n_checks = 0;
    int          n_fail = 0;

    flash_update_engine #(
        .POLL_TIMEOUT (24'd8)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_addr              (cmd_addr),
        .cmd_words             (cmd_words),
        .cmd_erase             (cmd_erase),
        .din_valid             (din_valid),
        .din_ready             (din_ready),
        .din_data              (din_data),
        .busy                  (busy),
        .done                  (done),
        .error                 (error),
        .ams_mem_read          (ams_mem_read),
        .ams_mem_write         (ams_mem_write),
        .ams_mem_address       (ams_mem_address),
        .ams_mem_burstcount    (ams_mem_burstcount),
        .ams_mem_writedata     (ams_mem_writedata),
        .ams_mem_waitrequest   (ams_mem_waitrequest),
        .ams_mem_readdata      (ams_mem_readdata),
        .ams_mem_readdatavalid (ams_mem_readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model: samples the bus on the falling edge (what the next rising
    // edge will accept), then drives its responses just after the rising edge.
    initial begin : slave
        bit          rd_pending;
        int          wait_cnt;
        bit          prev_stalled;
        logic [16:0] pa;
        logic [6:0]  pb;
        logic [31:0] pd;
        logic        pw;
        logic        pr;
        rd_pending            = 1'b0;
        wait_cnt              = 0;
        prev_stalled          = 1'b0;
        ams_mem_waitrequest   = 1'b0;
        ams_mem_readdatavalid = 1'b0;
        ams_mem_readdata      = 32'h0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stalled = 1'b0;
                rd_pending   = 1'b0;
            end else begin
                if (prev_stalled) begin
                    checkOutput("stall_addr", 64'(ams_mem_address), 64'(pa));
                    checkOutput("stall_bc", 64'(ams_mem_burstcount), 64'(pb));
                    checkOutput("stall_wdata", 64'(ams_mem_writedata), 64'(pd));
                    checkOutput("stall_write", 64'(ams_mem_write), 64'(pw));
                    checkOutput("stall_read", 64'(ams_mem_read), 64'(pr));
                end
                if (ams_mem_write && !ams_mem_waitrequest)
                    log_q.push_back('{1'b0, ams_mem_address, ams_mem_burstcount, ams_mem_writedata});
                if (ams_mem_read && !ams_mem_waitrequest) begin
                    log_q.push_back('{1'b1, ams_mem_address, ams_mem_burstcount, 32'h0});
                    rd_pending = 1'b1;
                end
                prev_stalled = (ams_mem_write || ams_mem_read) && ams_mem_waitrequest;
                pa = ams_mem_address;
                pb = ams_mem_burstcount;
                pd = ams_mem_writedata;
                pw = ams_mem_write;
                pr = ams_mem_read;
            end
            @(posedge clock);
            #1;
            ams_mem_readdatavalid = rd_pending;
            if (rd_pending)
                ams_mem_readdata = (status_q.size() > 0) ? status_q.pop_front() : status_default;
            else
                ams_mem_readdata = 32'h0;
            rd_pending = 1'b0;
            if ((ams_mem_write || ams_mem_read) && wait_cnt < stall_cycles) begin
                ams_mem_waitrequest = 1'b1;
                wait_cnt++;
            end else begin
                ams_mem_waitrequest = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expW(input logic [16:0] addr, input logic [6:0] bc, input logic [31:0] data);
        exp_q.push_back('{1'b0, addr, bc, data});
    endtask

    task automatic expR(input logic [16:0] addr);
        exp_q.push_back('{1'b1, addr, 7'd1, 32'h0});
    endtask

    task automatic expBurst(input logic [16:0] addr, input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) expW(addr, 7'(n), first + 32'(i));
    endtask

    task automatic compareLog(input string name);
        int n;
        checkOutput($sformatf("%s_count", name), 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_kind%0d", name, i), 64'(log_q[i].is_read), 64'(exp_q[i].is_read));
            checkOutput($sformatf("%s_addr%0d", name, i), 64'(log_q[i].addr), 64'(exp_q[i].addr));
            checkOutput($sformatf("%s_bc%0d", name, i), 64'(log_q[i].bc), 64'(exp_q[i].bc));
            if (!exp_q[i].is_read)
                checkOutput($sformatf("%s_data%0d", name, i), 64'(log_q[i].data), 64'(exp_q[i].data));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_done"}, 64'(done), 64'd0);
        checkOutput({name, "_error"}, 64'(error), 64'd0);
        checkOutput({name, "_din_ready"}, 64'(din_ready), 64'd0);
        checkOutput({name, "_read"}, 64'(ams_mem_read), 64'd0);
        checkOutput({name, "_write"}, 64'(ams_mem_write), 64'd0);
        checkOutput({name, "_address"}, 64'(ams_mem_address), 64'd0);
        checkOutput({name, "_burstcount"}, 64'(ams_mem_burstcount), 64'd0);
        checkOutput({name, "_writedata"}, 64'(ams_mem_writedata), 64'd0);
    endtask

    task automatic feedData(input int n, input logic [31:0] base, input int gap);
        int  i;
        int  budget;
        bit  acc;
        i      = 0;
        budget = 0;
        while (i < n && !cmd_finished && budget < 5000) begin
            din_valid = 1'b1;
            din_data  = base + 32'(i);
            @(negedge clock);
            acc = din_ready;
            @(posedge clock);
            #1;
            budget++;
            if (acc) begin
                i++;
                din_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic waitDone(input bit exp_immediate, input bit exp_err);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 5000 && !seen) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                checkOutput("busy_after_accept", 64'(busy), 64'd1);
                checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                checkOutput("error_cleared", 64'(error), 64'd0);
            end
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", 64'(seen), 64'd1);
        cmd_finished = 1'b1;
        if (seen) begin
            checkOutput("error_at_done", 64'(error), 64'(exp_err));
            if (exp_immediate) checkOutput("done_latency", 64'(cyc), 64'd1);
            @(negedge clock);
            checkOutput("done_pulse", 64'(done), 64'd0);
            checkOutput("cmd_ready_after", 64'(cmd_ready), 64'd1);
            checkOutput("error_sticky", 64'(error), 64'(exp_err));
        end
    endtask

    // Issues one command (caller is aligned just after a rising edge) and
    // streams its data words until done is observed.
    task automatic applyStimulus(input logic [31:0] addr, input int words, input bit erase,
                                 input int gap, input logic [31:0] base, input bit exp_err);
        log_q.delete();
        cmd_finished = 1'b0;
        cmd_valid    = 1'b1;
        cmd_addr     = addr;
        cmd_words    = 24'(words);
        cmd_erase    = erase;
        @(negedge clock);
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        fork
            feedData(words, base, gap);
            waitDone(words == 0, exp_err);
        join
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut(input string name);
        reset_n = 1'b0;
        #1;
        checkResetOutputs(name);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : main
        int i;
        int budget;
        bit acc;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_words = 24'h0;
        cmd_erase = 1'b0;
        din_valid = 1'b0;
        din_data  = 32'h0;
        #12;
        checkResetOutputs("rst0");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] T1: single 4-word burst after reset");
        applyStimulus(32'h0000_0100, 4, 1'b0, 0, 32'hA000_0000, 1'b0);
        expW(17'h10064, 7'd1, 32'h0);
        expBurst(17'h00040, 4, 32'hA000_0000);
        compareLog("t1");

        $display("[TB] T2: page-split burst, cached offset, low address bits ignored");
        applyStimulus(32'h0000_00FB, 4, 1'b0, 0, 32'hB000_0000, 1'b0);
        expBurst(17'h0003E, 2, 32'hB000_0000);
        expBurst(17'h00040, 2, 32'hB000_0002);
        compareLog("t2");

        $display("[TB] T2z: zero-word command");
        applyStimulus(32'h0000_1000, 0, 1'b0, 0, 32'h0, 1'b0);
        compareLog("t2z");

        $display("[TB] T3: crossing a 64K-word offset window");
        resetDut("rst1");
        @(posedge clock);
        #1;
        applyStimulus(32'h0003_FFF8, 4, 1'b0, 0, 32'hC000_0000, 1'b0);
        expW(17'h10064, 7'd1, 32'h0);
        expBurst(17'h0FFFE, 2, 32'hC000_0000);
        expW(17'h10064, 7'd1, 32'h1);
        expBurst(17'h00000, 2, 32'hC000_0002);
        compareLog("t3");

        $display("[TB] T4: erase with status polling");
        status_q.push_back(32'h1);
        status_q.push_back(32'h1);
        status_q.push_back(32'h0);
        applyStimulus(32'h0001_0000, 1, 1'b1, 0, 32'hD000_0000, 1'b0);
        expW(17'h10064, 7'd1, 32'h0);
        expW(17'h10007, 7'd1, 32'h0001_0000);
        expR(17'h10002);
        expR(17'h10002);
        expR(17'h10002);
        expBurst(17'h04000, 1, 32'hD000_0000);
        compareLog("t4");

        $display("[TB] T5: erase poll timeout");
        status_default = 32'h1;
        applyStimulus(32'h0002_0000, 2, 1'b1, 0, 32'hE000_0000, 1'b1);
        status_default = 32'h0;
        expW(17'h10007, 7'd1, 32'h0002_0000);
        for (int k = 0; k < 8; k++) expR(17'h10002);
        compareLog("t5");

        $display("[TB] T6: stalled slave and gaps in the data stream");
        stall_cycles = 3;
        applyStimulus(32'h0000_0200, 6, 1'b0, 2, 32'h6000_0000, 1'b0);
        expBurst(17'h00080, 6, 32'h6000_0000);
        compareLog("t6");

        $display("[TB] T7: reset in the middle of a burst");
        log_q.delete();
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0300;
        cmd_words = 24'd8;
        cmd_erase = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        i      = 0;
        budget = 0;
        while (log_q.size() < 2 && budget < 500) begin
            din_valid = (i < 8);
            din_data  = 32'h7000_0000 + 32'(i);
            @(negedge clock);
            acc = din_ready && din_valid;
            @(posedge clock);
            #1;
            if (acc) i++;
            budget++;
        end
        din_valid = 1'b0;
        checkOutput("t7_burst_started", 64'(log_q.size() >= 2), 64'd1);
        checkOutput("t7_write_before_reset", 64'(ams_mem_write), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        @(negedge clock);
        checkResetOutputs("rst_mid_edge");
        stall_cycles = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        expBurst(17'h000C0, 8, 32'h7000_0000);
        exp_q = exp_q[0:1];
        compareLog("t7");

        $display("[TB] T8: recovery after reset");
        @(posedge clock);
        #1;
        applyStimulus(32'h0000_0400, 3, 1'b0, 0, 32'h8000_0000, 1'b0);
        expW(17'h10064, 7'd1, 32'h0);
        expBurst(17'h00100, 3, 32'h8000_0000);
        compareLog("t8");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_update_engine.md
Name: flash_update_engine

Overview:
- Upstream master for the ASMI flash controller's Avalon-MM slave port (ams_mem_*). Converts a command plus a 32-bit data stream into flash programming traffic.
- Traffic per command: page-offset CSR writes, optional sector erase with status polling, and page-aligned write bursts.
- Sources: firmware-update path (UART/host mailbox) supplies the command and the data words.

Parameters:
- BURST_MAX, 64, max words per write burst; also the flash page size in words; power of 2, ≤64.
- SECTOR_WORDS, 16384, erase sector size in words (64 KB).
- CSR_OFFSET_REG, 16'h0064, CSR word address of the page-offset register.
- CSR_ERASE_REG, 16'h0007, CSR word address of the sector-erase register.
- CSR_STATUS_REG, 16'h0002, CSR word address of the flash status register; bit0 = WIP.
- POLL_TIMEOUT, 24'd10_000_000, max status reads before an erase is declared failed.

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  32  flash byte address; bits[1:0] ignored
- cmd_words  in  24  number of 32-bit words
- cmd_erase  in  1  erase each sector before first write into it
- din_valid  in  1  data valid
- din_ready  out  1  data accept
- din_data  in  32  data word
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at command end
- error  out  1  erase timeout; sticky until next cmd accept
- ams_mem_read  out  1  Avalon read
- ams_mem_write  out  1  Avalon write
- ams_mem_address  out  17  bit16 = CSR select; [15:0] = word address
- ams_mem_burstcount  out  7  burst length
- ams_mem_writedata  out  32  write data
- ams_mem_waitrequest  in  1  slave stall
- ams_mem_readdata  in  32  read data
- ams_mem_readdatavalid  in  1  read data valid

Behaviour:

Reset and address handling
- Reset: all outputs 0 except cmd_ready = 1. State = IDLE. cur_ofs = 16'hFFFF (invalid), so the first command always writes the offset register. FIFO empty.
- Command accept: cmd_valid && cmd_ready. Latch waddr = cmd_addr[31:2] (30 bits), rem = cmd_words, erase flag. Clear error.
- cmd_words == 0: done pulses the cycle after accept. No bus traffic.
- Word address split: offset = waddr[29:16]; memory address = {1'b0, waddr[15:0]}. CSR accesses drive address {1'b1, reg}.

Avalon rules
- Address, burstcount, read/write and writedata are held stable while waitrequest = 1.
- A write beat completes on write && !waitrequest.
- Reads are burstcount 1; the engine waits for readdatavalid.
- CSR writes use burstcount 1.

FSM
- IDLE: on accept → CHK.
- CHK: if rem == 0 → DONE. Else if waddr[29:16] != cur_ofs → SET_OFS. Else if erase && (waddr % SECTOR_WORDS == 0 || first word of command) → ERASE. Else → FILL.
- SET_OFS: write CSR_OFFSET_REG with data {16'b0, waddr[29:16]} (upper offset bits zero). On completion, cur_ofs updates → CHK.
- ERASE: write CSR_ERASE_REG with data {waddr[29:0], 2'b00} truncated to the sector base. Clear poll count → POLL_RD.
- POLL_RD: read CSR_STATUS_REG → POLL_WAIT.
- POLL_WAIT: on readdatavalid:
  - bit0 == 0 → FILL.
  - Else if poll count == POLL_TIMEOUT-1 → ERR.
  - Else increment poll count → POLL_RD.
- FILL: blen = min(rem, BURST_MAX − (waddr % BURST_MAX)). Bursts never cross a flash page, so never a 64K-word window or a sector. din_ready = !fifo_full. Stay until FIFO count ≥ blen → WRITE.
- WRITE: issue a write burst of blen words from the FIFO, one word per accepted beat. write stays high until the last beat. FIFO pops on beat accept. After the last beat: waddr += blen, rem -= blen → CHK.
- DONE: done = 1 for one cycle → IDLE.
- ERR: error = 1, done = 1 for one cycle → IDLE. Remaining words are not consumed.

Boundary conditions
- din_ready is deasserted outside FILL/WRITE.
- During WRITE, the FIFO may keep filling while not full. Words beyond the current burst stay for the next burst.
- waddr wrap past 30 bits: ignored. The command is the caller's responsibility.
- Reset mid-burst: immediate abort. The bus is released (write = 0). The slave's partial burst is not completed.

Decomposition:
- Package flash_update_pkg holds:
  - state enum (IDLE, CHK, SET_OFS, ERASE, POLL_RD, POLL_WAIT, FILL, WRITE, DONE, ERR);
  - CSR register address constants;
  - WIP bit index.
- Sub-module flash_update_fifo: synchronous FIFO, 32-bit × BURST_MAX, with push/pop, full, empty and count outputs, and first-word-fall-through read.

Test Plan:
1. cmd_addr = 0x0000_0100, words = 4, erase = 0 → CSR write addr 0x10064 data 0x0; then burst count 4 at addr 0x00040 with data in order; done pulse.
2. cmd_addr = 0x0000_00F8, words = 4 → two bursts: count 2 at 0x0003E, then count 2 at 0x00040; only one offset write.
3. cmd_addr = 0x0003_FFF8, words = 4 → offset 0 write, burst 2 at 0x0FFFE, offset write data 0x1, burst 2 at 0x00000.
4. cmd_addr = 0x0001_0000, erase = 1, words = 1; status returns 1, 1, 0 → erase write data 0x0001_0000 to 0x10007, three reads of 0x10002, then write burst; error = 0.
5. erase = 1, status stuck at 1, POLL_TIMEOUT = 8 → exactly 8 status reads, then error = 1 and done pulse; no memory write. error clears on the next accept.
6. waitrequest held high 3 cycles per beat plus din_valid gaps → address, burstcount and writedata stable while stalled, no lost or duplicated words. Reset asserted mid-burst → all outputs return to reset values next edge.
